// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing constants
// for the push-button conditioner.
package button_conditioner_pkg;

  localparam int DEB_CYCLES_DEF    = 500000;
  localparam int REPEAT_CYCLES_DEF = 25000000;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PULSE,
    HOLD,
    RELEASE_WAIT
  } btn_state_e;

endpackage

// File: rtl/button_cond_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM,
// press/release debounce counter and auto-repeat counter.
module button_cond_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_dpb,
  output logic o_scen,
  output logic o_mcen,
  output logic o_ccen
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [1:0]    r_sync;
  btn_state_e    r_state;
  btn_state_e    w_state_nxt;
  logic [DW-1:0] r_deb;
  logic [DW-1:0] w_deb_nxt;
  logic [RW-1:0] r_rep;
  logic [RW-1:0] w_rep_nxt;
  logic          w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_state <= IDLE;
      r_deb   <= '0;
      r_rep   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_deb   <= w_deb_nxt;
      r_rep   <= w_rep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb;
    w_rep_nxt   = r_rep;
    unique case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_deb_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s)
          w_state_nxt = IDLE;
        else if (r_deb == DEB_LAST)
          w_state_nxt = PULSE;
        else
          w_deb_nxt = r_deb + 1'b1;
      end
      PULSE: begin
        w_state_nxt = HOLD;
        w_rep_nxt   = '0;
      end
      HOLD: begin
        if (w_s) begin
          if (r_rep == REP_LAST)
            w_rep_nxt = '0;
          else
            w_rep_nxt = r_rep + 1'b1;
        end else begin
          w_state_nxt = RELEASE_WAIT;
          w_deb_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = HOLD;
          w_rep_nxt   = '0;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_deb_nxt = r_deb + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // repeat tick is the HOLD cycle where the counter sits at terminal count
  logic w_pulse;
  logic w_hold;
  logic w_rel;
  logic w_wrap;

  assign w_pulse = (r_state == PULSE);
  assign w_hold  = (r_state == HOLD);
  assign w_rel   = (r_state == RELEASE_WAIT);
  assign w_wrap  = w_hold && (r_rep == REP_LAST);

  assign o_dpb  = w_pulse | w_hold | w_rel;
  assign o_scen = w_pulse;
  assign o_mcen = w_pulse | w_wrap;
  assign o_ccen = w_pulse | w_hold;

endmodule

// File: rtl/button_conditioner.sv
// Four independent debounced button channels
// with single, multi and continuous enables.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  output logic [3:0] DPBs,
  output logic [3:0] SCENs,
  output logic [3:0] MCENs,
  output logic [3:0] CCENs
);

  for (genvar i = 0; i < 4; i++) begin : g_ch
    button_cond_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .i_btn (buttons[i]),
      .o_dpb (DPBs[i]),
      .o_scen(SCENs[i]),
      .o_mcen(MCENs[i]),
      .o_ccen(CCENs[i])
    );
  end

endmodule
